// File: rtl/param_seq_detector_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_ARMED} state_e;

  localparam int unsigned DefLen      = 3;
  localparam int unsigned DefPattern  = 'b101;
  localparam int unsigned MaxLenLimit = 16;

  function automatic int unsigned len_clamp(input int unsigned len, input int unsigned max_len);
    if (len == 0) return 1;
    if (len > max_len) return max_len;
    return len;
  endfunction

  // Ones in the low `len` positions, sized for the largest supported pattern.
  function automatic logic [MaxLenLimit-1:0] low_mask(input int unsigned len);
    logic [MaxLenLimit-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MaxLenLimit; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/param_seq_detector_if.sv
// Configuration, serial input and status bundle of param_seq_detector.
// SEQ_DET_MASK_EN adds the cfg_mask don't-care field.
interface param_seq_detector_if #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 8
);
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               din_valid;
  logic               din;
  logic               flag;
  logic [CNT_W-1:0]   hit_count;
  logic               armed;
`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] cfg_mask;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_mask, din_valid, din,
    input  flag, hit_count, armed
  );
  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_mask, din_valid, din,
    output flag, hit_count, armed
  );
`else
  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    input  flag, hit_count, armed
  );
  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, din_valid, din,
    output flag, hit_count, armed
  );
`endif
endinterface

// File: rtl/param_seq_detector_sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial pattern detector with registered hit pulse and saturating count.
// Define SEQ_DET_MASK_EN to enable per-position don't-care masking.
module param_seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned        CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DefPattern),
  parameter int unsigned        DEF_LEN     = DefLen
) (
  input logic                 clk,
  input logic                 rst,
  param_seq_detector_if.slave bus
);
  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_shift, care;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d, fill_inc;
  logic [LEN_W:0]     fill_plus;
  logic [MaxLenLimit-1:0] low_full;
  logic               ovl_q, ovl_d, flag_q, flag_d, match, hit_inc;

`ifdef SEQ_DET_MASK_EN
  logic [MAX_LEN-1:0] mask_q, mask_d;

  always_comb mask_d = bus.cfg_load ? bus.cfg_mask : mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mask_q <= '0;
    else     mask_q <= mask_d;
  end

  always_comb care = low_full[MAX_LEN-1:0] & ~mask_q;
`else
  always_comb care = low_full[MAX_LEN-1:0];
`endif

  always_comb begin
    hist_shift = {hist_q[MAX_LEN-2:0], bus.din};
    fill_plus  = {1'b0, fill_q} + (LEN_W+1)'(1);
    fill_inc   = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_plus[LEN_W-1:0];
    low_full   = low_mask(32'(len_q));
    // Newest bit sits at bit 0, so the low len_q bits line up with pat_q directly.
    match      = bus.din_valid && (fill_plus >= {1'b0, len_q}) &&
                 (((hist_shift ^ pat_q) & care) == '0);
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    flag_d  = 1'b0;
    hit_inc = 1'b0;
    if (bus.cfg_load) begin
      pat_d   = bus.cfg_pattern;
      len_d   = LEN_W'(len_clamp(32'(bus.cfg_len), MAX_LEN));
      ovl_d   = bus.cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = ST_EMPTY;
    end else if (bus.din_valid) begin
      hist_d  = hist_shift;
      fill_d  = fill_inc;
      flag_d  = match;
      hit_inc = match;
      unique case (state_q)
        ST_EMPTY, ST_FILL: state_d = (fill_inc >= len_q) ? ST_ARMED : ST_FILL;
        ST_ARMED:          state_d = ST_ARMED;
        default:           state_d = ST_EMPTY;
      endcase
      if (match && !ovl_q) begin
        fill_d  = '0;
        state_d = ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      pat_q   <= DEF_PATTERN;
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      fill_q  <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      flag_q  <= flag_d;
    end
  end

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_hit_cnt (
    .clk(clk),
    .rst(rst),
    .inc(hit_inc),
    .clr(bus.cfg_load),
    .q  (bus.hit_count)
  );

  assign bus.flag  = flag_q;
  assign bus.armed = (state_q == ST_ARMED);
endmodule
